// File: rtl/imem_fetch_unit.sv
// Loadable instruction RAM: filled through the load port in LOAD, serves fetches in RUN.
// Fetch latency 1 cycle; req_ready drops while a held response is not being taken.
module imem_fetch_unit #(
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 64,
  parameter logic [DATA_W-1:0] NOP    = '0,
  localparam int               AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic              ld_err,
  output logic              loading,
  output logic [AW:0]       prog_len,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_fault
);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_prog_len;
  logic              r_ld_err;
  logic              r_rsp_valid;
  logic              r_rsp_fault;
  logic [DATA_W-1:0] r_rsp_instr;

  logic              w_ld_in_range;
  logic              w_ld_wr;
  logic [AW:0]       w_ld_len;
  logic [29:0]       w_idx;
  logic              w_fault;
  logic              w_req_ready;
  logic              w_accept;

  // Constant 1 for any driven address; goes unknown when ld_addr carries X/Z bits,
  // which steers the write into the reject branch instead of corrupting memory.
  assign w_ld_in_range = (^ld_addr) | ~(^ld_addr);
  assign w_ld_wr       = (r_state == S_LOAD) && ld_en && w_ld_in_range;
  assign w_ld_len      = {1'b0, ld_addr} + (AW+1)'(1);

  assign w_idx       = req_addr[31:2];
  assign w_fault     = (req_addr[1:0] != 2'b00) ||
                       (w_idx >= {{(30-AW-1){1'b0}}, r_prog_len});
  assign w_req_ready = (r_state == S_RUN) && !ld_start && (!r_rsp_valid || rsp_ready);
  assign w_accept    = req_valid && w_req_ready;

  // Program storage is deliberately not reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (w_ld_wr) r_mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_prog_len  <= '0;
      r_ld_err    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_instr <= NOP;
    end else begin
      r_ld_err <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (ld_en) begin
            if (w_ld_in_range) begin
              if (w_ld_len > r_prog_len) r_prog_len <= w_ld_len;
            end else begin
              r_ld_err <= 1'b1;
            end
          end
          if (ld_done) r_state <= S_RUN;
        end
        S_RUN: begin
          r_ld_err <= ld_en;
          if (ld_start && !r_rsp_valid) begin
            r_state    <= S_LOAD;
            r_prog_len <= '0;
          end
        end
        default: r_state <= S_LOAD;
      endcase

      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_fault <= w_fault;
        r_rsp_instr <= w_fault ? NOP : r_mem[req_addr[AW+1:2]];
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign ld_err    = r_ld_err;
  assign loading   = (r_state == S_LOAD);
  assign prog_len  = r_prog_len;
  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_instr = r_rsp_instr;
  assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed + randomized bench for imem_fetch_unit against an array/length reference model.
module tb_imem_fetch_unit;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_start, ld_en, ld_done, ld_err, loading;
  logic [AW-1:0]     ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [AW:0]       prog_len;
  logic              req_valid, req_ready;
  logic [31:0]       req_addr;
  logic              rsp_valid, rsp_ready, rsp_fault;
  logic [DATA_W-1:0] rsp_instr;

  always #5 clk = ~clk;

  imem_fetch_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NOP(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_done(ld_done), .ld_err(ld_err), .loading(loading),
    .prog_len(prog_len), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_fault(rsp_fault)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: word array plus visible length
  logic [31:0] m_mem [DEPTH];
  int          m_len;

  logic [31:0] prog [6] = '{32'h20020014, 32'h2003001e, 32'h20050000,
                            32'h10a00001, 32'h00432820, 32'hac050014};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input bit done);
    ld_en = 1'b1; ld_addr = AW'(a); ld_data = d; ld_done = done;
    tick();
    ld_en = 1'b0; ld_done = 1'b0;
    m_mem[a] = d;
    if (a + 1 > m_len) m_len = a + 1;
    chk("ld_err_on_write", ld_err, 0);
    chk("prog_len_after_write", prog_len, m_len);
    chk("loading_after_write", loading, done ? 0 : 1);
  endtask

  task automatic fetch(input logic [31:0] a);
    bit          f;
    logic [31:0] e;
    f = (a % 4 != 0) || (int'(a / 4) >= m_len);
    e = f ? 32'h0 : m_mem[a / 4];
    req_valid = 1'b1; req_addr = a;
    #1;
    chk("req_ready_fetch", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("rsp_valid_fetch", rsp_valid, 1);
    chk("rsp_instr_fetch", rsp_instr, e);
    chk("rsp_fault_fetch", rsp_fault, f);
  endtask

  initial begin
    rst = 1'b1; ld_start = 0; ld_en = 0; ld_done = 0; ld_addr = '0; ld_data = '0;
    req_valid = 0; req_addr = '0; rsp_ready = 0; m_len = 0;
    #3;
    chk("rst_loading", loading, 1);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_instr", rsp_instr, 0);
    chk("rst_rsp_fault", rsp_fault, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_req_ready", req_ready, 0);
    tick(); tick();
    rst = 1'b0;

    // Load the sample program, ld_done with the last word
    for (int i = 0; i < 6; i++) wr(i, prog[i], i == 5);

    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) fetch(32'(i * 4));
    fetch(32'h02); fetch(32'h18); fetch(32'h100);

    // Backpressure: response must hold while rsp_ready is low
    fetch(32'h04);
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h08;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req_ready", req_ready, 0);
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_instr", rsp_instr, 32'h2003001e);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_drain_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("bp_next_instr", rsp_instr, 32'h20050000);
    chk("bp_next_valid", rsp_valid, 1);

    // Write attempt in RUN is rejected
    ld_en = 1'b1; ld_addr = '0; ld_data = 32'hFFFF_FFFF;
    tick();
    ld_en = 1'b0;
    chk("run_ld_err_pulse", ld_err, 1);
    tick();
    chk("run_ld_err_clear", ld_err, 0);
    fetch(32'h00);

    repeat (24) fetch($urandom_range(0, 'h11F));

    // Reload request is ignored while a response is held
    tick();
    chk("drain_idle", rsp_valid, 0);
    rsp_ready = 1'b0;
    fetch(32'h0C);
    ld_start = 1'b1;
    #1;
    chk("reload_req_ready", req_ready, 0);
    tick();
    chk("reload_held_loading", loading, 0);
    chk("reload_held_len", prog_len, m_len);
    chk("reload_held_valid", rsp_valid, 1);
    chk("reload_held_instr", rsp_instr, m_mem[3]);
    rsp_ready = 1'b1;
    tick();
    chk("reload_drained", rsp_valid, 0);
    chk("reload_still_run", loading, 0);
    tick();
    m_len = 0;
    chk("reload_loading", loading, 1);
    chk("reload_len", prog_len, 0);
    ld_start = 1'b0; req_valid = 1'b1;
    #1;
    chk("reload_blocked", req_ready, 0);
    req_valid = 1'b0;

    // Partial random reload: skipped low words keep their old contents
    for (int i = 0; i < 12; i++)
      if (i >= 6 || $urandom_range(0, 1) == 1) wr(i, $urandom, i == 11);
    repeat (24) fetch($urandom_range(0, 'h3F));

    // Asynchronous reset while a response is held
    fetch(32'h00);
    rsp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    m_len = 0;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_loading", loading, 1);
    chk("arst_prog_len", prog_len, 0);
    chk("arst_rsp_instr", rsp_instr, 0);
    chk("arst_req_ready", req_ready, 0);
    tick();
    rst = 1'b0;

    // Top index saturates prog_len at DEPTH; memory survived reset
    wr(DEPTH - 1, $urandom, 1);
    chk("sat_prog_len", prog_len, DEPTH);
    rsp_ready = 1'b1;
    fetch(32'hFC); fetch(32'h00); fetch(32'h1C); fetch(32'h100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
